// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the song sequencer slice.
//   - FSM state encoding (state_e)
//   - default key-code and duration field widths
//   - song ROM contents: packed per-song note/duration constants and the
//     length table, plus lookup helpers used by song_rom.
// Note i of a song sits in bits [i*NOTE_W +: NOTE_W] of its packed note
// constant (duration: [i*DUR_W +: DUR_W]), so note 0 is the least
// significant field.
package song_pkg;

  localparam int NOTE_W_DEF  = 4;
  localparam int DUR_W_DEF   = 8;
  localparam int ROM_SONGS   = 5;
  localparam int ROM_MAX_LEN = 32;
  localparam int ROM_LEN_W   = $clog2(ROM_MAX_LEN + 1);
  localparam int NOTES_BITS  = ROM_MAX_LEN * NOTE_W_DEF;
  localparam int DURS_BITS   = ROM_MAX_LEN * DUR_W_DEF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_KEY = 3'd2,
    GAP      = 3'd3,
    NOTE     = 3'd4
  } state_e;

  typedef struct packed {
    logic [NOTE_W_DEF-1:0] note;
    logic [DUR_W_DEF-1:0]  dur;
  } rom_word_t;

  // Song 0: notes {3,5}, durations {1,2}
  localparam logic [NOTES_BITS-1:0] SONG0_NOTES = NOTES_BITS'(128'h53);
  localparam logic [DURS_BITS-1:0]  SONG0_DURS  = DURS_BITS'(256'h0201);
  localparam logic [ROM_LEN_W-1:0]  SONG0_LEN   = ROM_LEN_W'(2);
  // Song 1: notes {7,2,9}, durations {0,1,3}; a zero duration plays as 1
  localparam logic [NOTES_BITS-1:0] SONG1_NOTES = NOTES_BITS'(128'h927);
  localparam logic [DURS_BITS-1:0]  SONG1_DURS  = DURS_BITS'(256'h030100);
  localparam logic [ROM_LEN_W-1:0]  SONG1_LEN   = ROM_LEN_W'(3);
  // Song 2: rising run {1,2,3,4}, all duration 2
  localparam logic [NOTES_BITS-1:0] SONG2_NOTES = NOTES_BITS'(128'h4321);
  localparam logic [DURS_BITS-1:0]  SONG2_DURS  = DURS_BITS'(256'h02020202);
  localparam logic [ROM_LEN_W-1:0]  SONG2_LEN   = ROM_LEN_W'(4);
  // Song 3: single note 8, duration 4
  localparam logic [NOTES_BITS-1:0] SONG3_NOTES = NOTES_BITS'(128'h8);
  localparam logic [DURS_BITS-1:0]  SONG3_DURS  = DURS_BITS'(256'h04);
  localparam logic [ROM_LEN_W-1:0]  SONG3_LEN   = ROM_LEN_W'(1);
  // Song 4 is an empty slot (length 0) and falls to the default arms below.

  function automatic logic [ROM_LEN_W-1:0] song_length(input logic [2:0] song);
    case (song)
      3'd0:    song_length = SONG0_LEN;
      3'd1:    song_length = SONG1_LEN;
      3'd2:    song_length = SONG2_LEN;
      3'd3:    song_length = SONG3_LEN;
      default: song_length = '0;
    endcase
  endfunction

  function automatic rom_word_t song_word(input logic [2:0] song, input logic [4:0] idx);
    logic [NOTES_BITS-1:0] notes;
    logic [DURS_BITS-1:0]  durs;
    case (song)
      3'd0:    begin notes = SONG0_NOTES; durs = SONG0_DURS; end
      3'd1:    begin notes = SONG1_NOTES; durs = SONG1_DURS; end
      3'd2:    begin notes = SONG2_NOTES; durs = SONG2_DURS; end
      3'd3:    begin notes = SONG3_NOTES; durs = SONG3_DURS; end
      default: begin notes = '0;          durs = '0;         end
    endcase
    song_word.note = NOTE_W_DEF'(notes >> {idx, 2'b00});
    song_word.dur  = DUR_W_DEF'(durs >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: synchronous-read song ROM, one cycle of latency.
// Ports:
//   clk   in  clock
//   song  in  song number (out-of-range reads return zeros)
//   idx   in  note index  (out-of-range reads return zeros)
//   note  out key code of the addressed note
//   dur   out duration of the addressed note, in ticks
//   len   out number of notes in the addressed song, clamped to MAX_LEN
module song_rom
  import song_pkg::*;
#(
  parameter int NUM_SONGS = 5,
  parameter int MAX_LEN   = 32,
  parameter int NOTE_W    = NOTE_W_DEF,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int SEL_W     = $clog2(NUM_SONGS),
  parameter int IDX_W     = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic [SEL_W-1:0]  song,
  input  logic [IDX_W-1:0]  idx,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  dur,
  output logic [IDX_W-1:0]  len
);

  logic                 song_ok;
  logic                 idx_ok;
  rom_word_t            word;
  logic [ROM_LEN_W-1:0] raw_len;

  always_comb begin
    song_ok = (32'(song) < NUM_SONGS) && (32'(song) < ROM_SONGS);
    idx_ok  = (32'(idx) < MAX_LEN) && (32'(idx) < ROM_MAX_LEN);
    word    = song_word(3'(song), 5'(idx));
    raw_len = song_length(3'(song));
  end

  // NOTE: the read register has no reset; like a RAM output it is only
  // consumed one cycle after a valid address, so a reset value buys nothing.
  always_ff @(posedge clk) begin
    note <= (song_ok && idx_ok) ? NOTE_W'(word.note) : '0;
    dur  <= (song_ok && idx_ok) ? DUR_W'(word.dur) : '0;
    if (!song_ok)
      len <= '0;
    else if (32'(raw_len) > MAX_LEN)
      len <= IDX_W'(MAX_LEN);
    else
      len <= IDX_W'(raw_len);
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: plays a song from song_rom as a timed stream of key codes
// with a gate, in auto-play or learn mode. Each note is preceded by a silent
// gap; in learn mode the sequencer first waits for the matching key.
// Optional build macro: SONG_LOOP_EN -- when defined the song restarts from
// note 0 at its end (done still pulses) instead of returning to idle.
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   start       pulse: latch song_sel/learn, play from note 0 (also restarts)
//   stop        pulse: abort to idle, wins over start
//   song_sel    song number; values >= NUM_SONGS are ignored
//   learn       0 = auto-play, 1 = learn mode
//   key_valid   pulse: player pressed key_code
//   key_code    pressed key
//   key         current (or expected) note
//   key_on      gate to the tone generator
//   note_idx    index of the current note
//   busy        high whenever not idle
//   done        pulse at end of song
//   hit, miss   learn-mode pulses for a correct / wrong key press
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_SONGS   = 5,
  parameter int MAX_LEN     = 32,
  parameter int NOTE_W      = NOTE_W_DEF,
  parameter int DUR_W       = DUR_W_DEF,
  parameter int TICK_CYCLES = 50000,
  parameter int GAP_CYCLES  = 50000000,
  parameter int SEL_W       = $clog2(NUM_SONGS),
  parameter int IDX_W       = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [SEL_W-1:0]  song_sel,
  input  logic              learn,
  input  logic              key_valid,
  input  logic [NOTE_W-1:0] key_code,
  output logic [NOTE_W-1:0] key,
  output logic              key_on,
  output logic [IDX_W-1:0]  note_idx,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              miss
);

  // Plain-vector state constants keep the register a simple logic vector.
  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_FETCH    = FETCH;
  localparam logic [2:0] ST_WAIT_KEY = WAIT_KEY;
  localparam logic [2:0] ST_GAP      = GAP;
  localparam logic [2:0] ST_NOTE     = NOTE;

  // One counter times both the gap and the note, so it must hold the larger.
  localparam longint NOTE_MAX = ((longint'(1) << DUR_W) - 1) * longint'(TICK_CYCLES);
  localparam longint CNT_MAX  = (longint'(GAP_CYCLES) > NOTE_MAX) ? longint'(GAP_CYCLES) : NOTE_MAX;
  localparam int     CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  logic [2:0]        state, state_next;
  logic [SEL_W-1:0]  song_q;
  logic              learn_q;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CNT_W-1:0]  note_len;
  logic [IDX_W-1:0]  idx_next;

  logic [SEL_W-1:0]  rom_song;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic [IDX_W-1:0]  rom_len;
  logic [DUR_W-1:0]  dur_eff;

  logic start_ok;
  logic act;
  logic end_of_song;
  logic key_match;

  // The ROM is addressed with next-cycle values so its registered output is
  // already valid during the single FETCH cycle that consumes it.
  song_rom #(
    .NUM_SONGS (NUM_SONGS),
    .MAX_LEN   (MAX_LEN),
    .NOTE_W    (NOTE_W),
    .DUR_W     (DUR_W),
    .SEL_W     (SEL_W),
    .IDX_W     (IDX_W)
  ) u_rom (
    .clk  (clk),
    .song (rom_song),
    .idx  (idx_next),
    .note (rom_note),
    .dur  (rom_dur),
    .len  (rom_len)
  );

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    start_ok    = start && (32'(song_sel) < NUM_SONGS);
    act         = !stop && !start_ok;
    end_of_song = (note_idx >= rom_len);
    key_match   = (key_code == key);
    dur_eff     = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
    rom_song    = start_ok ? song_sel : song_q;
    state_next  = state;
    idx_next    = note_idx;

    if (stop) begin
      state_next = ST_IDLE;
      idx_next   = '0;
    end else if (start_ok) begin
      state_next = ST_FETCH;
      idx_next   = '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (end_of_song) begin
            idx_next = '0;
`ifdef SONG_LOOP_EN
            state_next = ST_FETCH;
`else
            state_next = ST_IDLE;
`endif
          end else begin
            state_next = learn_q ? ST_WAIT_KEY : ST_GAP;
          end
        end
        ST_WAIT_KEY: begin
          if (key_valid && key_match)
            state_next = ST_GAP;
        end
        ST_GAP: begin
          if (cnt == GAP_LAST)
            state_next = ST_NOTE;
        end
        ST_NOTE: begin
          if (cnt == note_len - CNT_W'(1)) begin
            state_next = ST_FETCH;
            idx_next   = note_idx + IDX_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // Counter restarts on every state entry and only runs in the timed states.
    if ((state_next == state) && ((state == ST_GAP) || (state == ST_NOTE)))
      cnt_next = cnt + CNT_W'(1);
    else
      cnt_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      song_q   <= '0;
      learn_q  <= 1'b0;
      cnt      <= '0;
      note_len <= '0;
      note_idx <= '0;
      key      <= '0;
      key_on   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      note_idx <= idx_next;

      if (start_ok && !stop) begin
        song_q  <= song_sel;
        learn_q <= learn;
      end

      // key only changes here, so it is stable across the whole GAP and NOTE.
      if ((state == ST_FETCH) && act && !end_of_song) begin
        key      <= rom_note;
        note_len <= CNT_W'(dur_eff) * CNT_W'(TICK_CYCLES);
      end

      busy   <= (state_next != ST_IDLE);
      key_on <= (state_next == ST_NOTE);
      done   <= (state == ST_FETCH) && act && end_of_song;
      hit    <= (state == ST_WAIT_KEY) && act && key_valid && key_match;
      miss   <= (state == ST_WAIT_KEY) && act && key_valid && !key_match;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_CYCLES = 4, GAP_CYCLES = 2.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_song_sequencer;

  localparam int NUM_SONGS = 5;
  localparam int MAX_LEN   = 32;
  localparam int NOTE_W    = 4;
  localparam int DUR_W     = 8;
  localparam int SEL_W     = $clog2(NUM_SONGS);
  localparam int IDX_W     = $clog2(MAX_LEN + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [SEL_W-1:0]  song_sel;
  logic              learn;
  logic              key_valid;
  logic [NOTE_W-1:0] key_code;
  logic [NOTE_W-1:0] key;
  logic              key_on;
  logic [IDX_W-1:0]  note_idx;
  logic              busy;
  logic              done;
  logic              hit;
  logic              miss;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  song_sequencer #(
    .NUM_SONGS   (NUM_SONGS),
    .MAX_LEN     (MAX_LEN),
    .NOTE_W      (NOTE_W),
    .DUR_W       (DUR_W),
    .TICK_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .song_sel  (song_sel),
    .learn     (learn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key       (key),
    .key_on    (key_on),
    .note_idx  (note_idx),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .miss      (miss)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  on_cycles;
    bit  seen_done;
    logic [31:0] exp_on, exp_key, exp_done, exp_busy;

    rst = 1'b1; start = 1'b0; stop = 1'b0; song_sel = '0; learn = 1'b0;
    key_valid = 1'b0; key_code = '0;
    #12;
    check("rst_key",      32'(key), 0);
    check("rst_key_on",   32'(key_on), 0);
    check("rst_note_idx", 32'(note_idx), 0);
    check("rst_busy",     32'(busy), 0);
    check("rst_done",     32'(done), 0);
    check("rst_hit",      32'(hit), 0);
    check("rst_miss",     32'(miss), 0);
    rst = 1'b0;
    tick();

    // Auto play, song 0: notes {3,5}, durs {1,2} -> 4 on, then 8 on.
    song_sel = 3'd0; learn = 1'b0; start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      start = 1'b0;
      exp_on   = 32'(((k >= 4) && (k <= 7)) || ((k >= 11) && (k <= 18)));
      exp_key  = (k < 2) ? 0 : ((k < 9) ? 3 : 5);
      exp_done = 32'(k == 20);
`ifdef SONG_LOOP_EN
      exp_busy = 1;
      if (k == 21) exp_key = 3;
`else
      exp_busy = 32'(k < 20);
`endif
      check($sformatf("t1_key_on_k%0d", k), 32'(key_on), exp_on);
      check($sformatf("t1_key_k%0d", k),    32'(key), exp_key);
      check($sformatf("t1_done_k%0d", k),   32'(done), exp_done);
      check($sformatf("t1_busy_k%0d", k),   32'(busy), exp_busy);
      if (k == 5)  check("t1_idx_k5", 32'(note_idx), 0);
      if (k == 12) check("t1_idx_k12", 32'(note_idx), 1);
      if (k == 20) check("t1_idx_k20", 32'(note_idx), 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t1_stopped_busy", 32'(busy), 0);

    // Learn mode, expected note 3: wrong key 7 then key 3.
    song_sel = 3'd0; learn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t2_wait_key",    32'(key), 3);
    check("t2_wait_key_on", 32'(key_on), 0);
    check("t2_wait_busy",   32'(busy), 1);
    key_valid = 1'b1; key_code = 4'd7;
    tick();
    key_valid = 1'b0;
    check("t2_miss",        32'(miss), 1);
    check("t2_miss_hit",    32'(hit), 0);
    check("t2_miss_key_on", 32'(key_on), 0);
    tick();
    check("t2_miss_pulse",  32'(miss), 0);
    key_valid = 1'b1; key_code = 4'd3;
    tick();
    key_valid = 1'b0;
    check("t2_hit",         32'(hit), 1);
    check("t2_hit_miss",    32'(miss), 0);
    check("t2_hit_key_on",  32'(key_on), 0);
    // A press during GAP must be ignored.
    key_valid = 1'b1; key_code = 4'd9;
    tick();
    key_valid = 1'b0;
    check("t2_gap_hit",     32'(hit), 0);
    check("t2_gap_miss",    32'(miss), 0);
    check("t2_gap_key_on",  32'(key_on), 0);
    tick();
    check("t2_note_key_on", 32'(key_on), 1);
    check("t2_note_key",    32'(key), 3);
    check("t2_note_miss",   32'(miss), 0);

    // stop in mid-NOTE.
    tick();
    check("t2_note2_key_on", 32'(key_on), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_stop_key_on", 32'(key_on), 0);
    check("t2_stop_busy",   32'(busy), 0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("t2_stop_no_done", 32'(seen_done), 0);

    // Invalid song select is ignored.
    song_sel = 3'd5; learn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_busy",   32'(busy), 0);
    check("t3_key_on", 32'(key_on), 0);
    check("t3_key",    32'(key), 3);
    tick();
    check("t3_busy2",  32'(busy), 0);

    // Empty song 4: done two cycles after start.
    song_sel = 3'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy", 32'(busy), 1);
    check("t4_done_early", 32'(done), 0);
    tick();
    check("t4_done", 32'(done), 1);
`ifndef SONG_LOOP_EN
    check("t4_busy_end", 32'(busy), 0);
`endif
    check("t4_key", 32'(key), 3);
    tick();
    check("t4_done_pulse", 32'(done), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Song 1: first duration 0 plays as 1 tick (4 cycles).
    song_sel = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t5_key_first", 32'(key), 7);
    tick();
    tick();
    check("t5_on_k4", 32'(key_on), 1);
    for (int k = 5; k <= 7; k++) begin
      tick();
      check($sformatf("t5_on_k%0d", k), 32'(key_on), 1);
    end
    tick();
    check("t5_off_k8", 32'(key_on), 0);
    check("t5_idx_k8", 32'(note_idx), 1);
    tick();
    check("t5_key_second", 32'(key), 2);

    // Restart while busy with song 3: note 8, duration 4 -> 16 on cycles.
    song_sel = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_busy", 32'(busy), 1);
    check("t5_restart_idx",  32'(note_idx), 0);
    check("t5_restart_key",  32'(key), 2);
    tick();
    check("t5_restart_new_key", 32'(key), 8);
    tick();
    check("t5_restart_gap", 32'(key_on), 0);
    tick();
    check("t5_restart_on", 32'(key_on), 1);
    on_cycles = 1;
    seen_done = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (key_on) on_cycles++;
      if (done) seen_done = 1'b1;
    end
    check("t5_on_cycles", 32'(on_cycles), 16);
    check("t5_done_seen", 32'(seen_done), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Asynchronous reset while in GAP.
    song_sel = 3'd0; learn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t6_pre_key",  32'(key), 3);
    check("t6_pre_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_key",      32'(key), 0);
    check("t6_key_on",   32'(key_on), 0);
    check("t6_note_idx", 32'(note_idx), 0);
    check("t6_busy",     32'(busy), 0);
    check("t6_done",     32'(done), 0);
    check("t6_hit",      32'(hit), 0);
    check("t6_miss",     32'(miss), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_idle_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
